// File: rtl/aes_tcdm_port_arbiter_pkg.sv
// Shared types and defaults for the TCDM port arbiter: bus widths, default sizing and request payload.
package aes_tcdm_port_arbiter_pkg;

  localparam int unsigned AES_TCDM_ARB_MP    = 2;
  localparam int unsigned AES_TCDM_ARB_DEPTH = 4;
  localparam int unsigned AES_TCDM_AW        = 32;
  localparam int unsigned AES_TCDM_DW        = 32;
  localparam int unsigned AES_TCDM_BEW       = AES_TCDM_DW / 8;

  typedef struct packed {
    logic [AES_TCDM_AW-1:0]  add;
    logic                    wen;
    logic [AES_TCDM_BEW-1:0] be;
    logic [AES_TCDM_DW-1:0]  data;
  } tcdm_req_t;

endpackage

// File: rtl/aes_tcdm_port_arbiter_if.sv
// Upstream (MP engine ports) and downstream (single interconnect port) TCDM signals of the arbiter.
interface aes_tcdm_port_arbiter_if
  import aes_tcdm_port_arbiter_pkg::*;
#(
  parameter int unsigned MP = AES_TCDM_ARB_MP
);

  logic [MP-1:0]                   in_req;
  logic [MP-1:0]                   in_gnt;
  logic [MP-1:0][AES_TCDM_AW-1:0]  in_add;
  logic [MP-1:0]                   in_wen;
  logic [MP-1:0][AES_TCDM_BEW-1:0] in_be;
  logic [MP-1:0][AES_TCDM_DW-1:0]  in_data;
  logic [MP-1:0][AES_TCDM_DW-1:0]  in_r_data;
  logic [MP-1:0]                   in_r_valid;

  logic                            out_req;
  logic                            out_gnt;
  logic [AES_TCDM_AW-1:0]          out_add;
  logic                            out_wen;
  logic [AES_TCDM_BEW-1:0]         out_be;
  logic [AES_TCDM_DW-1:0]          out_data;
  logic [AES_TCDM_DW-1:0]          out_r_data;
  logic                            out_r_valid;

  // Arbiter side
  modport slave (
    input  in_req, in_add, in_wen, in_be, in_data,
    output in_gnt, in_r_data, in_r_valid,
    output out_req, out_add, out_wen, out_be, out_data,
    input  out_gnt, out_r_data, out_r_valid
  );

  // Environment side: engine streamers upstream plus interconnect downstream
  modport master (
    output in_req, in_add, in_wen, in_be, in_data,
    input  in_gnt, in_r_data, in_r_valid,
    input  out_req, out_add, out_wen, out_be, out_data,
    output out_gnt, out_r_data, out_r_valid
  );

endinterface

// File: rtl/aes_tcdm_port_arbiter_id_fifo.sv
// FIFO of issuing-port IDs for granted transactions still waiting for their in-order response.
module aes_tcdm_port_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap by natural overflow since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/aes_tcdm_port_arbiter.sv
// Round-robin funnel of MP engine TCDM ports onto one interconnect port, with in-order response routing.
module aes_tcdm_port_arbiter
  import aes_tcdm_port_arbiter_pkg::*;
#(
  parameter int unsigned MP    = AES_TCDM_ARB_MP,
  parameter int unsigned DEPTH = AES_TCDM_ARB_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  aes_tcdm_port_arbiter_if.slave bus,
  output logic                   err_o
);

  localparam int unsigned IDW = $clog2(MP);
  typedef logic [IDW-1:0] tcdm_port_id_t;

  tcdm_port_id_t rr_ptr_q, rr_ptr_d;
  tcdm_port_id_t winner, head;
  logic          found, hs, resp, fifo_full, fifo_empty;
  logic          err_q, err_d;
  int unsigned   idx;
  tcdm_req_t     win_req;

  // First requesting port at or above rr_ptr, wrapping MP-1 -> 0
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < MP; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= MP) idx = idx - MP;
      if (!found && bus.in_req[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    win_req = '0;
    if (found) begin
      win_req.add  = bus.in_add[winner];
      win_req.wen  = bus.in_wen[winner];
      win_req.be   = bus.in_be[winner];
      win_req.data = bus.in_data[winner];
    end
  end

  assign bus.out_add  = win_req.add;
  assign bus.out_wen  = win_req.wen;
  assign bus.out_be   = win_req.be;
  assign bus.out_data = win_req.data;

  // No full bypass: a same-cycle pop does not reopen the request
  assign bus.out_req = rst_ni && found && !fifo_full;
  assign hs          = bus.out_req && bus.out_gnt;
  assign resp        = bus.out_r_valid && !fifo_empty;

  always_comb begin
    bus.in_gnt     = '0;
    bus.in_r_valid = '0;
    for (int unsigned p = 0; p < MP; p++) begin
      bus.in_gnt[p]     = hs && (winner == IDW'(p));
      bus.in_r_valid[p] = resp && (head == IDW'(p));
    end
  end

  assign bus.in_r_data = {MP{bus.out_r_data}};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = (winner == IDW'(MP - 1)) ? '0 : winner + IDW'(1);
    err_d = err_q | (bus.out_r_valid & fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;

  aes_tcdm_port_arbiter_id_fifo #(
    .DEPTH (DEPTH),
    .W     (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .pop_i   (resp),
    .data_i  (winner),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_aes_tcdm_port_arbiter.sv
// Directed bench for aes_tcdm_port_arbiter with MP=2, DEPTH=4; drives at negedge, checks 1ns later.
module tb_aes_tcdm_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  aes_tcdm_port_arbiter_if #(.MP(2)) bus ();
  logic err_o;

  aes_tcdm_port_arbiter #(
    .MP    (2),
    .DEPTH (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.in_req      = '0;
    bus.in_add      = '0;
    bus.in_wen      = '0;
    bus.in_be       = '0;
    bus.in_data     = '0;
    bus.out_gnt     = 1'b0;
    bus.out_r_data  = '0;
    bus.out_r_valid = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [1:0]  exp_gnt [4];
  logic [1:0]  exp_rv  [4];
  logic [31:0] rdat;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    rst_n       = 1'b0;
    bus.in_req  = 2'b11;
    bus.out_gnt = 1'b1;
    step(); #1;
    chk("rst_out_req", 32'(bus.out_req), 32'd0);
    chk("rst_in_gnt", 32'(bus.in_gnt), 32'd0);
    chk("rst_in_r_valid", 32'(bus.in_r_valid), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    step();
    idle();
    rst_n = 1'b1;

    // Single port0 read, response two cycles after grant
    step();
    bus.in_req[0] = 1'b1; bus.in_add[0] = 32'h1000; bus.in_wen[0] = 1'b1;
    bus.in_be[0] = 4'hF; bus.out_gnt = 1'b1;
    #1;
    chk("t1_out_req", 32'(bus.out_req), 32'd1);
    chk("t1_out_add", bus.out_add, 32'h1000);
    chk("t1_out_wen", 32'(bus.out_wen), 32'd1);
    chk("t1_in_gnt", 32'(bus.in_gnt), 32'd1);
    step(); idle(); #1;
    chk("t1_gnt_pulse", 32'(bus.in_gnt), 32'd0);
    chk("t1_out_req_idle", 32'(bus.out_req), 32'd0);
    chk("t1_out_add_idle", bus.out_add, 32'd0);
    step();
    bus.out_r_valid = 1'b1; bus.out_r_data = 32'hCAFE0001;
    #1;
    chk("t1_r_valid", 32'(bus.in_r_valid), 32'd1);
    chk("t1_r_data", bus.in_r_data[0], 32'hCAFE0001);
    step(); idle(); #1;
    chk("t1_r_valid_clr", 32'(bus.in_r_valid), 32'd0);
    chk("t1_err", 32'(err_o), 32'd0);

    // Both ports requesting; port0 was served last so port1 wins first
    exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_rv  = '{2'b00, 2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) begin
      step();
      bus.in_req = 2'b11; bus.out_gnt = 1'b1;
      bus.in_add[0] = 32'h100 + 32'(k); bus.in_add[1] = 32'h200 + 32'(k);
      bus.out_r_valid = (k > 0);
      bus.out_r_data  = 32'hA000_0000 + 32'(k);
      #1;
      chk($sformatf("t2_gnt%0d", k), 32'(bus.in_gnt), 32'(exp_gnt[k]));
      chk($sformatf("t2_add%0d", k), bus.out_add,
          (exp_gnt[k] == 2'b01) ? 32'h100 + 32'(k) : 32'h200 + 32'(k));
      chk($sformatf("t2_rv%0d", k), 32'(bus.in_r_valid), 32'(exp_rv[k]));
      if (k > 0) begin
        rdat = (exp_rv[k] == 2'b01) ? bus.in_r_data[0] : bus.in_r_data[1];
        chk($sformatf("t2_rdata%0d", k), rdat, 32'hA000_0000 + 32'(k));
      end
    end
    step(); idle();
    bus.out_r_valid = 1'b1; bus.out_r_data = 32'hA000_0004;
    #1;
    chk("t2_rv4", 32'(bus.in_r_valid), 32'b01);
    chk("t2_rdata4", bus.in_r_data[0], 32'hA000_0004);

    // Fill the ID FIFO: four grants, then request blocked
    for (int k = 0; k < 4; k++) begin
      step(); idle();
      bus.in_req = 2'b11; bus.out_gnt = 1'b1;
      #1;
      chk($sformatf("t3_gnt%0d", k), 32'(bus.in_gnt), (k % 2 == 0) ? 32'b10 : 32'b01);
    end
    step(); #1;
    chk("t3_full_req", 32'(bus.out_req), 32'd0);
    chk("t3_full_gnt", 32'(bus.in_gnt), 32'd0);
    step();
    bus.out_r_valid = 1'b1;
    #1;
    chk("t3_pop_rv", 32'(bus.in_r_valid), 32'b10);
    chk("t3_no_bypass", 32'(bus.out_req), 32'd0);
    step();
    bus.out_r_valid = 1'b0;
    #1;
    chk("t3_reopen_req", 32'(bus.out_req), 32'd1);
    chk("t3_reopen_gnt", 32'(bus.in_gnt), 32'b10);
    exp_rv = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) begin
      step(); idle();
      bus.out_r_valid = 1'b1;
      #1;
      chk($sformatf("t3_drain%0d", k), 32'(bus.in_r_valid), 32'(exp_rv[k]));
    end

    // Port0 read outstanding; port1 write granted while that response returns
    step(); idle();
    bus.in_req = 2'b01; bus.in_wen[0] = 1'b1; bus.out_gnt = 1'b1;
    #1;
    chk("t5_gnt0", 32'(bus.in_gnt), 32'b01);
    step(); idle();
    bus.in_req = 2'b10; bus.in_wen[1] = 1'b0; bus.in_be[1] = 4'b0011;
    bus.in_add[1] = 32'h2000; bus.in_data[1] = 32'h1234_5678; bus.out_gnt = 1'b1;
    bus.out_r_valid = 1'b1; bus.out_r_data = 32'hBEEF_0000;
    #1;
    chk("t5_rv0", 32'(bus.in_r_valid), 32'b01);
    chk("t5_rdata0", bus.in_r_data[0], 32'hBEEF_0000);
    chk("t5_gnt1", 32'(bus.in_gnt), 32'b10);
    chk("t5_be", 32'(bus.out_be), 32'h3);
    chk("t5_wen", 32'(bus.out_wen), 32'd0);
    chk("t5_data", bus.out_data, 32'h1234_5678);
    step(); idle();
    bus.out_r_valid = 1'b1;
    #1;
    chk("t5_rv1", 32'(bus.in_r_valid), 32'b10);
    chk("t5_err_pre", 32'(err_o), 32'd0);

    // Spurious response with nothing outstanding
    step(); idle();
    bus.out_r_valid = 1'b1;
    #1;
    chk("t4_spur_rv", 32'(bus.in_r_valid), 32'd0);
    step(); idle(); #1;
    chk("t4_err_set", 32'(err_o), 32'd1);
    step(); step(); step(); #1;
    chk("t4_err_sticky", 32'(err_o), 32'd1);

    // Three outstanding, then asynchronous reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      step(); idle();
      bus.in_req = 2'b11; bus.out_gnt = 1'b1;
      #1;
      chk($sformatf("t6_gnt%0d", k), 32'(bus.in_gnt), (k % 2 == 0) ? 32'b01 : 32'b10);
    end
    step();
    bus.out_r_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", 32'(bus.out_req), 32'd0);
    chk("t6_async_gnt", 32'(bus.in_gnt), 32'd0);
    chk("t6_async_rv", 32'(bus.in_r_valid), 32'd0);
    chk("t6_async_err", 32'(err_o), 32'd0);
    step(); idle();
    rst_n = 1'b1;
    // Late response after reset finds an empty FIFO
    step();
    bus.out_r_valid = 1'b1;
    #1;
    chk("t6_late_rv", 32'(bus.in_r_valid), 32'd0);
    step(); idle(); #1;
    chk("t6_late_err", 32'(err_o), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus.in_req = 2'b11; bus.out_gnt = 1'b1;
    #1;
    chk("t6_first_gnt", 32'(bus.in_gnt), 32'b01);
    chk("t6_err_clr", 32'(err_o), 32'd0);
    step(); idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
